// File: rtl/dta_egr_rcv_req_scheduler.sv
// Round-robin request scheduler: grants one channel at a time, issues a burst request,
// waits for the response and tracks the data beats. Optional watchdog: DTA_EGR_RCV_SCHED_TIMEOUT_EN.
module dta_egr_rcv_req_scheduler #(
    parameter int unsigned NUM_CH           = 4,
    parameter logic [15:0] MAX_BURST_LENGTH = 16'd4096,
    parameter logic [31:0] TIMEOUT_CYCLES   = 32'd65536
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_CH-1:0]      ch_req_valid,
    input  logic [16*NUM_CH-1:0]   ch_req_len,
    output logic [NUM_CH-1:0]      ch_req_ready,
    output logic                   req_tvalid,
    input  logic                   req_tready,
    output logic [63:0]            req_tdata,
    input  logic                   resp_tvalid,
    output logic                   resp_tready,
    input  logic [63:0]            resp_tdata,
    input  logic                   data_tvalid,
    input  logic                   data_tready,
    output logic                   busy,
    output logic [3:0]             sched_error,
    output logic [1:0]             dbg_state_o
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DATA      = 2'd3
    } state_e;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ch_req_ready is a combinational one-hot accept raised only in IDLE when a grant is made.

    state_e          state_q, state_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [15:0]     len_q, len_d;
    logic [10:0]     beats_q, beats_d;
    logic [2:0]      err_q, err_d;
    logic            timeout;
    logic            timeout_err;

    logic            grant_any;
    logic [CH_W-1:0] grant_idx;
    logic [15:0]     grant_len;
    logic [15:0]     grant_burst;
    logic            grant_fire;

    logic [15:0]     resp_len;
    logic [16:0]     resp_sum;
    logic            data_fire;
    logic            unused_resp_bits;

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            idx = (int'(ptr_q) + k) % int'(NUM_CH);
            if (!grant_any && ch_req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx[CH_W-1:0];
            end
        end
    end

    assign grant_len   = ch_req_len[{grant_idx, 4'd0} +: 16];
    assign grant_burst = (grant_len > MAX_BURST_LENGTH) ? MAX_BURST_LENGTH : grant_len;
    assign resp_len    = resp_tdata[63:48];
    assign resp_sum    = {1'b0, resp_len} + 17'd63;
    assign data_fire   = data_tvalid && data_tready;
    assign unused_resp_bits = ^resp_tdata[47:16];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ch_d       = ch_q;
        len_d      = len_q;
        beats_d    = beats_q;
        err_d      = err_q;
        grant_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    grant_fire = 1'b1;
                    ptr_d      = grant_idx;
                    if (grant_len == 16'd0) begin
                        err_d[0] = 1'b1;
                    end else begin
                        ch_d    = grant_idx;
                        len_d   = grant_burst;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (req_tready) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (resp_tvalid) begin
                    if (resp_tdata[15:0] != 16'(ch_q)) err_d[1] = 1'b1;
                    if (resp_len > len_q) err_d[2] = 1'b1;
                    if (resp_len == 16'd0) begin
                        state_d = IDLE;
                    end else begin
                        beats_d = resp_sum[16:6];
                        state_d = DATA;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (data_fire) begin
                    beats_d = beats_q - 11'd1;
                    if (beats_q == 11'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= CH_W'(NUM_CH - 1);
            ch_q    <= '0;
            len_q   <= '0;
            beats_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            len_q   <= len_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

`ifdef DTA_EGR_RCV_SCHED_TIMEOUT_EN
    logic [31:0] timer_q;
    logic        to_err_q;

    assign timeout     = (timer_q == TIMEOUT_CYCLES - 32'd1);
    assign timeout_err = to_err_q;

    // Timer is held at zero during REQ so it starts from zero on the first WAIT_RESP cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            timer_q  <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state_q == REQ) begin
                timer_q <= '0;
            end else if (state_q == WAIT_RESP) begin
                timer_q <= timer_q + 32'd1;
            end
            if (state_q == WAIT_RESP && !resp_tvalid && timeout) to_err_q <= 1'b1;
        end
    end
`else
    localparam logic [31:0] unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        ch_req_ready = '0;
        if (grant_fire && ap_rst_n) ch_req_ready[grant_idx] = 1'b1;
    end

    assign req_tvalid  = (state_q == REQ);
    assign req_tdata   = {len_q, 32'd0, 16'(ch_q)};
    assign resp_tready = (state_q == WAIT_RESP);
    assign busy        = (state_q != IDLE);
    assign sched_error = {timeout_err, err_q};
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dta_egr_rcv_req_scheduler.sv
// Bench for dta_egr_rcv_req_scheduler: directed scenarios plus randomized transactions
// checked against a transaction-level model (round-robin pick, clamp, beat count, sticky errors).
module tb_dta_egr_rcv_req_scheduler;
    localparam int          NUM_CH    = 4;
    localparam logic [15:0] MAX_BURST = 16'd4096;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n = 1'b0;
    logic [NUM_CH-1:0]    ch_req_valid = '0;
    logic [16*NUM_CH-1:0] ch_req_len = '0;
    logic [NUM_CH-1:0]    ch_req_ready;
    logic                 req_tvalid;
    logic                 req_tready = 1'b0;
    logic [63:0]          req_tdata;
    logic                 resp_tvalid = 1'b0;
    logic                 resp_tready;
    logic [63:0]          resp_tdata = '0;
    logic                 data_tvalid = 1'b0;
    logic                 data_tready = 1'b0;
    logic                 busy;
    logic [3:0]           sched_error;
    logic [1:0]           dbg_state;

    dta_egr_rcv_req_scheduler #(
        .NUM_CH(NUM_CH),
        .MAX_BURST_LENGTH(MAX_BURST),
        .TIMEOUT_CYCLES(32'd16)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .ch_req_valid(ch_req_valid),
        .ch_req_len(ch_req_len),
        .ch_req_ready(ch_req_ready),
        .req_tvalid(req_tvalid),
        .req_tready(req_tready),
        .req_tdata(req_tdata),
        .resp_tvalid(resp_tvalid),
        .resp_tready(resp_tready),
        .resp_tdata(resp_tdata),
        .data_tvalid(data_tvalid),
        .data_tready(data_tready),
        .busy(busy),
        .sched_error(sched_error),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 ap_clk = ~ap_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard / model ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    int          m_last = NUM_CH - 1;
    logic [3:0]  m_err = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_pick(input logic [NUM_CH-1:0] v, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (v[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
        return 0;
    endfunction

    function automatic logic [15:0] m_clamp(input logic [15:0] len);
        return (len > MAX_BURST) ? MAX_BURST : len;
    endfunction

    task automatic apply_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        m_last = NUM_CH - 1;
        m_err  = '0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks (all start and end on a falling edge) ----------------
    task automatic do_grant(input logic [NUM_CH-1:0] mask, input logic [16*NUM_CH-1:0] lens,
                            input bit keep, output int g, output logic [15:0] glen);
        ch_req_valid = mask;
        ch_req_len   = lens;
        #1;
        g    = m_pick(mask, m_last);
        glen = lens[16*g +: 16];
        check("grant_onehot", 64'(ch_req_ready), 64'(1) << g);
        @(negedge ap_clk);
        if (!keep) ch_req_valid = '0;
        m_last = g;
        if (glen == 16'd0) m_err[0] = 1'b1;
        else exp_q.push_back({m_clamp(glen), 32'd0, 16'(g)});
        check("busy_after_grant", 64'(busy), 64'(glen != 16'd0));
        check("req_tvalid_after_grant", 64'(req_tvalid), 64'(glen != 16'd0));
        check("err_after_grant", 64'(sched_error), 64'(m_err));
    endtask

    task automatic do_req(input int stall);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        data_tvalid = 1'b1;
        data_tready = 1'b1;
        for (int i = 0; i < stall; i++) begin
            check("req_hold_valid", 64'(req_tvalid), 64'd1);
            check("req_hold_data", req_tdata, e);
            check("no_grant_in_req", 64'(ch_req_ready), 64'd0);
            @(negedge ap_clk);
        end
        check("req_valid", 64'(req_tvalid), 64'd1);
        check("req_data", req_tdata, e);
        req_tready = 1'b1;
        @(negedge ap_clk);
        req_tready = 1'b0;
        check("req_dropped", 64'(req_tvalid), 64'd0);
        check("resp_tready_on", 64'(resp_tready), 64'd1);
    endtask

    task automatic do_resp(input int stall, input logic [15:0] rlen, input logic [15:0] rch,
                           input int g, input logic [15:0] burst);
        for (int i = 0; i < stall; i++) begin
            check("wait_resp_ready", 64'(resp_tready), 64'd1);
            @(negedge ap_clk);
        end
        resp_tvalid = 1'b1;
        resp_tdata  = {rlen, 32'($urandom), rch};
        @(negedge ap_clk);
        resp_tvalid = 1'b0;
        data_tvalid = 1'b0;
        data_tready = 1'b0;
        if (rch != 16'(g)) m_err[1] = 1'b1;
        if (rlen > burst) m_err[2] = 1'b1;
        check("err_after_resp", 64'(sched_error), 64'(m_err));
        check("busy_after_resp", 64'(busy), 64'(rlen != 16'd0));
        check("resp_tready_off", 64'(resp_tready), 64'd0);
    endtask

    task automatic do_data(input int beats);
        int got;
        int budget;
        got    = 0;
        budget = beats * 8 + 20;
        while (got < beats && budget > 0) begin
            check("data_busy", 64'(busy), 64'd1);
            check("no_grant_in_data", 64'(ch_req_ready), 64'd0);
            data_tvalid = ($urandom_range(0, 3) != 0);
            data_tready = ($urandom_range(0, 3) != 0);
            @(negedge ap_clk);
            if (data_tvalid && data_tready) got++;
            budget--;
        end
        data_tvalid = 1'b0;
        data_tready = 1'b0;
        check("data_beats", 64'(got), 64'(beats));
        check("idle_after_data", 64'(busy), 64'd0);
    endtask

    task automatic full_txn(input logic [NUM_CH-1:0] mask, input logic [16*NUM_CH-1:0] lens,
                            input bit keep, input bit rnd);
        int          g;
        logic [15:0] glen;
        logic [15:0] burst;
        logic [15:0] rlen;
        logic [15:0] rch;
        do_grant(mask, lens, keep, g, glen);
        if (glen == 16'd0) return;
        burst = m_clamp(glen);
        do_req($urandom_range(0, 3));
        rlen = burst;
        rch  = 16'(g);
        if (rnd && $urandom_range(0, 3) == 0) begin
            rlen = 16'($urandom_range(0, int'(burst) + 256));
            rch  = 16'($urandom_range(0, NUM_CH - 1));
        end
        do_resp($urandom_range(0, 3), rlen, rch, g, burst);
        do_data((int'(rlen) + 63) / 64);
    endtask

    function automatic logic [16*NUM_CH-1:0] all_len(input logic [15:0] len);
        return {NUM_CH{len}};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int                   g;
        logic [15:0]          glen;
        logic [16*NUM_CH-1:0] lens;

        // reset state, with requests already pending
        ch_req_valid = '1;
        ch_req_len   = all_len(16'd64);
        @(negedge ap_clk);
        check("rst_ready", 64'(ch_req_ready), 64'd0);
        check("rst_req_tvalid", 64'(req_tvalid), 64'd0);
        check("rst_req_tdata", req_tdata, 64'd0);
        check("rst_resp_tready", 64'(resp_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(sched_error), 64'd0);
        ch_req_valid = '0;
        apply_reset();

        // Test 1: ch0 len=128, two beats
        do_grant(4'b0001, all_len(16'd128), 1'b0, g, glen);
        check("t1_req_tdata", req_tdata, 64'h0080_0000_0000_0000);
        do_req(0);
        do_resp(0, 16'd128, 16'd0, g, 16'd128);
        do_data(2);
        check("t1_err", 64'(sched_error), 64'd0);

        // Test 3: ch2 len=10000 clamps to 4096, 64 beats
        lens = '0;
        lens[16*2 +: 16] = 16'd10000;
        do_grant(4'b0100, lens, 1'b0, g, glen);
        check("t3_burst", 64'(req_tdata[63:48]), 64'd4096);
        do_req(2);
        do_resp(1, 16'd4096, 16'd2, g, 16'd4096);
        do_data(64);

        // Test 2: all channels valid continuously -> 0,1,2,3,0
        apply_reset();
        for (int i = 0; i < 5; i++) full_txn(4'b1111, all_len(16'd64), 1'b1, 1'b0);
        ch_req_valid = '0;

        // Test 4: ch1 len=0 flags error, then ch2 wins
        lens = all_len(16'd64);
        lens[16*1 +: 16] = 16'd0;
        do_grant(4'b0010, lens, 1'b0, g, glen);
        check("t4_err0", 64'(sched_error[0]), 64'd1);
        full_txn(4'b1101, lens, 1'b0, 1'b0);

        // Test 5: ch1 len=256, response {512, ch3}
        do_grant(4'b0010, all_len(16'd256), 1'b0, g, glen);
        do_req(1);
        do_resp(0, 16'd512, 16'd3, g, 16'd256);
        check("t5_err21", 64'(sched_error[2:1]), 64'd3);
        do_data(8);

        // Test 6: no response
        do_grant(4'b0001, all_len(16'd64), 1'b0, g, glen);
        do_req(0);
`ifdef DTA_EGR_RCV_SCHED_TIMEOUT_EN
        repeat (15) @(negedge ap_clk);
        check("t6_busy_before_timeout", 64'(busy), 64'd1);
        @(negedge ap_clk);
        m_err[3] = 1'b1;
        check("t6_idle_on_timeout", 64'(busy), 64'd0);
        check("t6_err", 64'(sched_error), 64'(m_err));
`else
        repeat (40) @(negedge ap_clk);
        check("t6_still_waiting", 64'(busy), 64'd1);
        check("t6_resp_ready", 64'(resp_tready), 64'd1);
        check("t6_no_timeout_err", 64'(sched_error[3]), 64'd0);
        do_resp(0, 16'd64, 16'(g), g, 16'd64);
        do_data(1);
`endif

        // reset asserted mid-DATA
        do_grant(4'b0100, all_len(16'd640), 1'b0, g, glen);
        do_req(0);
        do_resp(0, 16'd640, 16'(g), g, 16'd640);
        data_tvalid = 1'b1;
        data_tready = 1'b1;
        repeat (3) @(negedge ap_clk);
        ch_req_valid = '1;
        ap_rst_n     = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ch_req_ready), 64'd0);
        check("mid_rst_req_tvalid", 64'(req_tvalid), 64'd0);
        check("mid_rst_req_tdata", req_tdata, 64'd0);
        check("mid_rst_resp_tready", 64'(resp_tready), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_err", 64'(sched_error), 64'd0);
        ch_req_valid = '0;
        data_tvalid  = 1'b0;
        data_tready  = 1'b0;
        apply_reset();
        repeat (3) begin
            @(negedge ap_clk);
            check("no_replay_valid", 64'(req_tvalid), 64'd0);
            check("no_replay_busy", 64'(busy), 64'd0);
        end
        full_txn(4'b1111, all_len(16'd100), 1'b0, 1'b0);

        // randomized transactions
        for (int t = 0; t < 150; t++) begin
            if (t % 30 == 0) apply_reset();
            for (int c = 0; c < NUM_CH; c++) begin
                case ($urandom_range(0, 9))
                    0:       lens[16*c +: 16] = 16'd0;
                    1:       lens[16*c +: 16] = 16'($urandom_range(4097, 12000));
                    default: lens[16*c +: 16] = 16'($urandom_range(1, 300));
                endcase
            end
            full_txn(4'($urandom_range(1, 15)), lens, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dta_egr_rcv_req_scheduler.md
DTA_EGR_RCV_REQ_SCHEDULER -- requirements
Module: dta_egr_rcv_req_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of requesting channels (2..16).
REQ-002 The block SHALL have parameter MAX_BURST_LENGTH, default 16'd4096, meaning the largest burst length in bytes issued per request.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd65536, meaning the response watchdog limit.
REQ-004 The block SHALL have ports, one per line:
- ap_clk  in  1  single clock
- ap_rst_n  in  1  reset, asynchronous, active-low
- ch_req_valid  in  NUM_CH  per-channel pending request
- ch_req_len  in  16*NUM_CH  per-channel byte length; channel i uses bits [16i+15:16i]
- ch_req_ready  out  NUM_CH  one-hot grant/accept pulse
- req_tvalid  out  1  request stream valid
- req_tready  in  1  request stream ready
- req_tdata  out  64  [63:48] burst_length, [47:16] zero, [15:0] channel index
- resp_tvalid  in  1  response valid
- resp_tready  out  1  response ready
- resp_tdata  in  64  [63:48] granted burst_length, [15:0] channel
- data_tvalid  in  1  data beat valid (observed)
- data_tready  in  1  data beat ready (observed)
- busy  out  1  state is not IDLE
- sched_error  out  4  sticky: [0] zero-length request, [1] resp channel mismatch, [2] resp length greater than request, [3] response timeout

Function
REQ-005 The block SHALL implement states IDLE, REQ, WAIT_RESP and DATA, with one transaction outstanding at a time.
REQ-006 In IDLE, when any ch_req_valid bit is set, the block SHALL grant the lowest-index valid channel at or after the last grant + 1 (mod NUM_CH) and pulse the matching ch_req_ready bit for one cycle.
REQ-007 On grant with len==0, the block SHALL set sched_error[0], issue no request and stay in IDLE; the round-robin pointer SHALL still advance.
REQ-008 On grant with len>0, the block SHALL register min(len, MAX_BURST_LENGTH) and the channel index, drive req_tvalid=1 in the next cycle and enter REQ.
REQ-009 In REQ, req_tvalid and req_tdata SHALL hold stable until req_tvalid&&req_tready, then go to WAIT_RESP.
REQ-010 resp_tready SHALL be 1 only in WAIT_RESP.
REQ-011 On resp handshake, a channel mismatch SHALL set sched_error[1] and a length larger than requested SHALL set sched_error[2]; both are checked in the same cycle.
REQ-012 On resp handshake, a response length of 0 SHALL return the block to IDLE; otherwise it SHALL load the beat counter with ceil(len/64) and enter DATA.
REQ-013 In DATA, each data_tvalid&&data_tready cycle SHALL decrement the counter; at the cycle where the counter equals 1 and a beat is accepted, the block SHALL return to IDLE.
REQ-014 A handshake that lands on the same cycle as a state transition SHALL be consumed exactly once, and data beats outside DATA SHALL be ignored.
REQ-015 The block SHALL have a latency of one cycle from the IDLE grant to req_tvalid, and one cycle from the final data beat to IDLE; a new grant is possible in the IDLE cycle that follows.

Reset
REQ-016 When ap_rst_n is asserted, the block SHALL asynchronously force state=IDLE, req_tvalid=0, req_tdata=0, resp_tready=0, ch_req_ready=0, busy=0, sched_error=0, the round-robin pointer to NUM_CH-1 (so channel 0 wins first), and the beat counter and timer to 0.
REQ-017 Reset asserted mid-transaction SHALL abandon the transaction without replaying it.

Configuration
REQ-018 With DTA_EGR_RCV_SCHED_TIMEOUT_EN defined, a cycle counter SHALL clear on entry to WAIT_RESP; if it reaches TIMEOUT_CYCLES without a resp handshake, the block SHALL set sched_error[3] and return to IDLE.
REQ-019 Without DTA_EGR_RCV_SCHED_TIMEOUT_EN, the block SHALL have no counter logic, sched_error[3] SHALL be tied to 0, and WAIT_RESP SHALL wait indefinitely.

Verification
REQ-020 Test 1: ch0 len=128, req_tready=1, resp {128,ch0}, 2 beats. Required: req_tdata=0x0080_0000_0000_0000, then IDLE after the 2nd beat, with sched_error=0.
REQ-021 Test 2: ch0..ch3 all valid continuously. Required: grant order 0,1,2,3,0, with exactly one ch_req_ready pulse per grant.
REQ-022 Test 3: ch2 len=10000. Required: req burst_length=4096; resp 4096 leads to 64 beats before IDLE.
REQ-023 Test 4: ch1 len=0. Required: sched_error[0]=1, no req_tvalid, and the next grant goes to ch2 if valid.
REQ-024 Test 5: ch1 len=256 with resp {512,ch3}. Required: sched_error[2:1]=2'b11, and the transfer takes 8 beats.
REQ-025 Test 6: with the macro defined and TIMEOUT_CYCLES=16, no resp. Required: sched_error[3]=1 and IDLE 16 cycles after entering WAIT_RESP; reset asserted mid-DATA clears all outputs immediately.
